// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and default widths for the single-port RAM controller.
package sp_ram_ctrl_pkg;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RSP_DEPTH  = 2;

  typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} gnt_e;
endpackage

// File: rtl/sp_ram_ctrl_rsp_fifo.sv
// In-order read-response buffer; storage is not reset, only pointers and occupancy.
module sp_ram_ctrl_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  // a full buffer may still take a push when the head leaves in the same cycle
  assign w_push  = i_push && (!o_full || i_pop);
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= inc(r_wptr);
      if (w_pop)  r_rptr <= inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end
endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller: one RAM op per cycle, in-order buffered read responses.
// Define SP_RAM_CTRL_RR_EN for round-robin arbitration (default: write has priority).
module sp_ram_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic          r_active, r_rd_pend;
  logic          w_wr_hs, w_rd_hs, w_space, w_full, w_empty;
  logic [CW-1:0] w_count;

  // the in-flight RAM word already owns a buffer slot, so count it as occupied
  assign w_space = !w_full && ((int'(w_count) + int'(r_rd_pend)) < RSP_DEPTH);

`ifdef SP_RAM_CTRL_RR_EN
  gnt_e r_last;

  assign wr_ready = r_active && !(rd_valid && w_space && (r_last == GNT_WR));
  assign rd_ready = r_active && w_space && !(wr_valid && (r_last == GNT_RD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last <= GNT_WR;
    else if (w_wr_hs) r_last <= GNT_WR;
    else if (w_rd_hs) r_last <= GNT_RD;
  end
`else
  assign wr_ready = r_active;
  assign rd_ready = r_active && !wr_valid && w_space;
`endif

  assign w_wr_hs  = wr_valid && wr_ready;
  assign w_rd_hs  = rd_valid && rd_ready;
  assign ram_we   = w_wr_hs;
  assign ram_addr = w_wr_hs ? wr_addr : rd_addr;
  assign ram_din  = wr_data;

  // r_active holds both readies low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_rd_pend <= 1'b0;
    end else begin
      r_active  <= 1'b1;
      r_rd_pend <= w_rd_hs;
    end
  end

  sp_ram_ctrl_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_pend),
    .i_din   (ram_dout),
    .i_pop   (rsp_ready),
    .o_dout  (rsp_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign rsp_valid = !w_empty;
endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Randomized scoreboard bench for sp_ram_ctrl with a behavioural RAM and reference memory.
module tb_sp_ram_ctrl;
  localparam int AW = 10, DW = 8, DEPTH = 2, NADDR = 32;

  logic          clk = 0, rst_n = 1;
  logic          wr_valid = 0, rd_valid = 0, rsp_ready = 0;
  logic          wr_ready, rd_ready, rsp_valid, ram_we;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0, ram_addr;
  logic [DW-1:0] wr_data = '0, rsp_data, ram_din, ram_dout;

  sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM: 1-cycle read, old data on read-during-write; output is noise unless a read is in flight
  logic [DW-1:0] mem [NADDR];
  logic [DW-1:0] ram_q, noise;
  logic          rd_issued;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[4:0]] <= ram_din;
    ram_q     <= mem[ram_addr[4:0]];
    rd_issued <= rd_valid && rd_ready;
  end
  always @(negedge clk) noise <= DW'($urandom);
  assign ram_dout = rd_issued ? ram_q : noise;

  typedef struct { logic [DW-1:0] d; int t; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] ref_mem [NADDR];
  int            total = 0, bad = 0, cyc = 0, ups = 0, n_rsp = 0;
  logic          last_wr = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ups <= rst_n ? ups + 1 : 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Request side: readiness rules, RAM port drive, and expected-response bookkeeping.
  task automatic req_model();
    logic space, ew, er, wh, rh;
    if (!rst_n) begin
      q.delete();
      last_wr = 1'b1;
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_rd_ready", 32'(rd_ready), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
    end else begin
      space = q.size() < DEPTH;
`ifdef SP_RAM_CTRL_RR_EN
      ew = (ups > 0) && !(rd_valid && space && last_wr);
      er = (ups > 0) && space && !(wr_valid && !last_wr);
`else
      ew = (ups > 0);
      er = (ups > 0) && !wr_valid && space;
`endif
      chk("wr_ready", 32'(wr_ready), 32'(ew));
      chk("rd_ready", 32'(rd_ready), 32'(er));
      wh = wr_valid && wr_ready;
      rh = rd_valid && rd_ready;
      chk("one_op", 32'(wh && rh), 0);
      if (wh) begin
        chk("ram_we", 32'(ram_we), 1);
        chk("ram_waddr", 32'(ram_addr), 32'(wr_addr));
        chk("ram_din", 32'(ram_din), 32'(wr_data));
        ref_mem[wr_addr[4:0]] = wr_data;
        last_wr = 1'b1;
      end else begin
        chk("ram_we_idle", 32'(ram_we), 0);
        if (rh) chk("ram_raddr", 32'(ram_addr), 32'(rd_addr));
      end
      if (rh) begin
        q.push_back('{d: ref_mem[rd_addr[4:0]], t: cyc});
        last_wr = 1'b0;
      end
    end
  endtask

  // Response monitor: head becomes visible two clocks after its read handshake.
  task automatic mon();
    logic ev;
    ev = rst_n && (q.size() > 0) && (cyc >= q[0].t + 2);
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (rsp_valid && q.size() > 0) begin
      chk("rsp_data", 32'(rsp_data), 32'(q[0].d));
      if (rsp_ready) begin
        void'(q.pop_front());
        n_rsp++;
      end
    end
  endtask

  always @(negedge clk) req_model();
  always @(negedge clk) begin
    #1;
    mon();
  end

  task automatic step(input logic wv, input int wa, input int wd,
                      input logic rv, input int ra, input logic rr);
    @(posedge clk);
    #1;
    wr_valid = wv; wr_addr = AW'(wa); wr_data = DW'(wd);
    rd_valid = rv; rd_addr = AW'(ra); rsp_ready = rr;
  endtask

  task automatic rd_req(input int a, input logic rr);
    step(0, 0, 0, 1, a, rr);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rd_ready) return;
      @(posedge clk);
      #1;
    end
    total++; bad++;
    $display("FAIL rd_req timeout: addr %0d never accepted", a);
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() > 0; n++) step(0, 0, 0, 0, 0, 1);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, want 0", q.size());
    end
  endtask

  initial begin
    int n0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NADDR; i++) step(1, i, i * 37 + 5, 0, 0, 1);

    // write then read the same address on the next cycle
    step(1, 'h10, 'hA5, 0, 0, 1);
    step(0, 0, 0, 1, 'h10, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #2;
    chk("raw_rsp_valid", 32'(rsp_valid), 1);
    chk("raw_rsp_data", 32'(rsp_data), 32'hA5);
    drain();

    // contention for four cycles
    for (int i = 0; i < 4; i++) step(1, 8 + i, 100 + i, 1, 8, 1);
    step(0, 0, 0, 0, 0, 1);
    drain();

    // buffer fills with consumer stalled, third read waits for a pop
    rd_req(1, 0);
    rd_req(2, 0);
    repeat (3) step(0, 0, 0, 1, 3, 0);
    @(negedge clk);
    chk("full_stall_rd_ready", 32'(rd_ready), 0);
    rd_req(3, 1);
    drain();

    // streaming reads with consumer always ready
    n0 = n_rsp;
    for (int i = 0; i < 8; i++) rd_req(i, 1);
    drain();
    chk("stream_count", 32'(n_rsp - n0), 8);

    // reset with one buffered response and one read in flight
    rd_req(4, 0);
    rd_req(5, 0);
    step(0, 0, 0, 0, 0, 0);
    #1 rst_n = 0;
    @(negedge clk);
    #2;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (6) step(0, 0, 0, 0, 0, 1);

    // write-only traffic with noisy ram_dout
    for (int i = 0; i < 10; i++) step(1, $urandom % NADDR, $urandom, 0, 0, 1);

    for (int i = 0; i < 500; i++)
      step($urandom % 2, $urandom % NADDR, $urandom, $urandom % 2, $urandom % NADDR,
           ($urandom % 4) != 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
